// File: rtl/tlx_sim_monitor_pkg.sv
// Shared types for the TLX simulation monitor: supervisor state encoding,
// first-error codes and the lowest-set-bit encoder used for error capture.
package tlx_sim_mon_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      DRAIN = 2'b10,
      DONE  = 2'b11
   } monState_t;

   localparam logic [1:0] ERR_FLAG    = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   // Index of the lowest set bit; 0 when the vector is empty.
   function automatic logic [4:0] lowestSetIdx(input logic [31:0] vec);
      logic [4:0] idx;
      idx = 5'd0;
      for (int i = 31; i >= 0; i--) begin
         if (vec[i]) idx = 5'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/tlx_sim_monitor_if.sv
// Channel inputs and supervisor outputs of the TLX simulation monitor.
// Optional macro TLX_SIM_MON_BREAKPOINT_EN adds the breakpoint signal.
interface tlx_sim_monitor_if #(
   parameter int NUM_CHAN = 4,
   parameter int CHAN_W   = 5,
   parameter int TIME_W   = 64
);
   logic                enable;
   logic [NUM_CHAN-1:0] chan_mask;
   logic [NUM_CHAN-1:0] chan_error;
   logic [NUM_CHAN-1:0] chan_heartbeat;
   logic [TIME_W-1:0]   sim_time;
   logic [1:0]          state;
   logic                err_valid;
   logic [CHAN_W-1:0]   err_chan;
   logic [1:0]          err_code;
   logic [TIME_W-1:0]   err_time;
   logic [NUM_CHAN-1:0] err_sticky;
   logic                finish_req;
`ifdef TLX_SIM_MON_BREAKPOINT_EN
   logic                breakpoint;
`endif

`ifdef TLX_SIM_MON_BREAKPOINT_EN
   modport master (
      output enable, chan_mask, chan_error, chan_heartbeat,
      input  sim_time, state, err_valid, err_chan, err_code, err_time,
             err_sticky, finish_req, breakpoint
   );
   modport slave (
      input  enable, chan_mask, chan_error, chan_heartbeat,
      output sim_time, state, err_valid, err_chan, err_code, err_time,
             err_sticky, finish_req, breakpoint
   );
`else
   modport master (
      output enable, chan_mask, chan_error, chan_heartbeat,
      input  sim_time, state, err_valid, err_chan, err_code, err_time,
             err_sticky, finish_req
   );
   modport slave (
      input  enable, chan_mask, chan_error, chan_heartbeat,
      output sim_time, state, err_valid, err_chan, err_code, err_time,
             err_sticky, finish_req
   );
`endif

endinterface

// File: rtl/tlx_sim_monitor_wdog.sv
// Single heartbeat watchdog: counts cycles without a heartbeat, pulses
// timeout once when the count reaches TIMEOUT-1, then saturates so it
// cannot refire until cleared. TIMEOUT=0 disables it entirely.
module tlx_sim_wdog
   import tlx_sim_mon_pkg::*;
#(
   parameter int WDOG_W  = 16,
   parameter int TIMEOUT = 1000
) (
   input  logic ha_pclock,
   input  logic ha_reset,
   input  logic clr,
   input  logic en,
   output logic timeout
);

   localparam logic [WDOG_W-1:0] TO_LAST = WDOG_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
   localparam logic [WDOG_W-1:0] TO_SAT  = WDOG_W'(TIMEOUT);

   logic [WDOG_W-1:0] count;

   // Timeout only on the exact terminal cycle; a heartbeat that cycle saves it.
   assign timeout = (TIMEOUT != 0) && en && !clr && (count == TO_LAST);

   // Count heartbeat-free cycles, holding once past the terminal value.
   always_ff @(posedge ha_pclock or posedge ha_reset) begin
      if (ha_reset) begin
         count <= '0;
      end else if (clr || (TIMEOUT == 0)) begin
         count <= '0;
      end else if (en && (count != TO_SAT)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/tlx_sim_monitor.sv
// TLX/AFU bench supervisor: simulation time, per-channel error and
// heartbeat supervision, first-error capture and RUN->DRAIN->DONE
// end-of-test sequencing. Optional macro TLX_SIM_MON_BREAKPOINT_EN adds a
// breakpoint pulse on first error and on DONE entry.
//
// state | meaning
// IDLE  | monitoring off, errors and watchdogs ignored
// RUN   | channels supervised, first error captured
// DRAIN | fixed settling period after an error
// DONE  | finish_req high until reset
module tlx_sim_monitor
   import tlx_sim_mon_pkg::*;
#(
   parameter int NUM_CHAN     = 4,
   parameter int CHAN_W       = 5,
   parameter int TIME_W       = 64,
   parameter int WDOG_W       = 16,
   parameter int TIMEOUT      = 1000,
   parameter int DRAIN_CYCLES = 16
) (
   input logic          ha_pclock,
   input logic          ha_reset,
   tlx_sim_monitor_if.slave mon
);

   localparam int DRN_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam int DRAIN_LAST = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;

   monState_t           stateQ;
   logic [TIME_W-1:0]   simTime;
   logic [TIME_W-1:0]   errTime;
   logic                errValid;
   logic [CHAN_W-1:0]   errChan;
   logic [1:0]          errCode;
   logic [NUM_CHAN-1:0] errSticky;
   logic                finishReq;
   logic [DRN_W-1:0]    drainCnt;

   logic [NUM_CHAN-1:0] active;
   logic [NUM_CHAN-1:0] tmoVec;
   logic [NUM_CHAN-1:0] flagVec;
   logic [NUM_CHAN-1:0] hitVec;
   logic [31:0]         flagWide;
   logic [4:0]          firstIdx;
   logic                firstIsFlag;
   logic                anyHit;
   logic                captureNow;
   logic                drainLast;

   assign active = ~mon.chan_mask;

   // Watchdogs run only in RUN; leaving RUN, masking or a heartbeat clears them.
   for (genvar g = 0; g < NUM_CHAN; g++) begin : gWdog
      tlx_sim_wdog #(
         .WDOG_W  (WDOG_W),
         .TIMEOUT (TIMEOUT)
      ) uWdog (
         .ha_pclock (ha_pclock),
         .ha_reset  (ha_reset),
         .clr       (mon.chan_heartbeat[g] | ~active[g] | (stateQ != RUN)),
         .en        (active[g] & (stateQ == RUN)),
         .timeout   (tmoVec[g])
      );
   end

   // Active error sources this cycle and the first-error selection.
   always_comb begin
      flagVec     = mon.chan_error & active & {NUM_CHAN{stateQ != IDLE}};
      hitVec      = flagVec | tmoVec;
      anyHit      = |hitVec;
      flagWide    = 32'(flagVec);
      firstIdx    = lowestSetIdx(32'(hitVec));
      firstIsFlag = flagWide[firstIdx];
      captureNow  = !errValid && (stateQ == RUN) && anyHit;
      drainLast   = (DRAIN_CYCLES == 0) || (drainCnt == DRN_W'(DRAIN_LAST));
   end

   // Free-running simulation time, independent of state.
   always_ff @(posedge ha_pclock or posedge ha_reset) begin
      if (ha_reset) simTime <= '0;
      else          simTime <= simTime + 1'b1;
   end

   // Supervisor FSM with drain timer and finish request.
   always_ff @(posedge ha_pclock or posedge ha_reset) begin
      if (ha_reset) begin
         stateQ    <= IDLE;
         drainCnt  <= '0;
         finishReq <= 1'b0;
      end else begin
         case (stateQ)
            IDLE: begin
               drainCnt <= '0;
               if (mon.enable) stateQ <= RUN;
            end
            RUN: begin
               drainCnt <= '0;
               if (anyHit)           stateQ <= DRAIN;
               else if (!mon.enable) stateQ <= IDLE;
            end
            DRAIN: begin
               if (drainLast) begin
                  stateQ    <= DONE;
                  finishReq <= 1'b1;
               end else begin
                  drainCnt <= drainCnt + 1'b1;
               end
            end
            DONE: finishReq <= 1'b1;
            default: stateQ <= IDLE;
         endcase
      end
   end

   // First-error capture (frozen once valid) and sticky per-channel history.
   always_ff @(posedge ha_pclock or posedge ha_reset) begin
      if (ha_reset) begin
         errValid  <= 1'b0;
         errChan   <= '0;
         errCode   <= 2'b00;
         errTime   <= '0;
         errSticky <= '0;
      end else begin
         errSticky <= errSticky | hitVec;
         if (captureNow) begin
            errValid <= 1'b1;
            errChan  <= CHAN_W'(firstIdx);
            errCode  <= firstIsFlag ? ERR_FLAG : ERR_TIMEOUT;
            errTime  <= simTime;
         end
      end
   end

`ifdef TLX_SIM_MON_BREAKPOINT_EN
   logic breakpointQ;

   // One-cycle pulse on first error capture and on entry to DONE.
   always_ff @(posedge ha_pclock or posedge ha_reset) begin
      if (ha_reset) breakpointQ <= 1'b0;
      else          breakpointQ <= captureNow | ((stateQ == DRAIN) && drainLast);
   end

   assign mon.breakpoint = breakpointQ;
`endif

   assign mon.sim_time   = simTime;
   assign mon.state      = stateQ;
   assign mon.err_valid  = errValid;
   assign mon.err_chan   = errChan;
   assign mon.err_code   = errCode;
   assign mon.err_time   = errTime;
   assign mon.err_sticky = errSticky;
   assign mon.finish_req = finishReq;

endmodule

// File: tb/tb_tlx_sim_monitor.sv
// Directed bench for tlx_sim_monitor (TIMEOUT=8, DRAIN_CYCLES=16).
module tb_tlx_sim_monitor;

   logic ha_pclock = 1'b0;
   logic ha_reset  = 1'b1;
   int   testCount = 0;
   int   failCount = 0;

   tlx_sim_monitor_if #(.NUM_CHAN(4), .CHAN_W(5), .TIME_W(64)) mon ();

   tlx_sim_monitor #(
      .NUM_CHAN     (4),
      .CHAN_W       (5),
      .TIME_W       (64),
      .WDOG_W       (16),
      .TIMEOUT      (8),
      .DRAIN_CYCLES (16)
   ) dut (
      .ha_pclock (ha_pclock),
      .ha_reset  (ha_reset),
      .mon       (mon)
   );

   always #5 ha_pclock = ~ha_pclock;

`ifdef TLX_SIM_MON_BREAKPOINT_EN
   int bpCount = 0;
   always @(negedge ha_pclock) if (mon.breakpoint === 1'b1) bpCount++;
`endif

   task automatic tick();
      @(posedge ha_pclock);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic doReset();
      mon.enable         = 1'b0;
      mon.chan_mask      = 4'b0000;
      mon.chan_error     = 4'b0000;
      mon.chan_heartbeat = 4'b0000;
      ha_reset = 1'b1;
      ticks(2);
      ha_reset = 1'b0;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
`ifdef TLX_SIM_MON_BREAKPOINT_EN
      int bpStart;
`endif
      // Reset then idle 10 cycles, errors present but ignored in IDLE.
      doReset();
      mon.chan_error = 4'b1111;
      ticks(10);
      check("idle_time",    mon.sim_time, 64'd10);
      check("idle_state",   64'(mon.state), 64'd0);
      check("idle_valid",   64'(mon.err_valid), 64'd0);
      check("idle_chan",    64'(mon.err_chan), 64'd0);
      check("idle_code",    64'(mon.err_code), 64'd0);
      check("idle_etime",   mon.err_time, 64'd0);
      check("idle_sticky",  64'(mon.err_sticky), 64'd0);
      check("idle_finish",  64'(mon.finish_req), 64'd0);

      // Full error run: enable at 5, error on ch2 at sim_time 40.
      doReset();
`ifdef TLX_SIM_MON_BREAKPOINT_EN
      bpStart = bpCount;
`endif
      mon.chan_heartbeat = 4'b1111;
      ticks(5);
      mon.enable = 1'b1;
      tick();
      check("a_run",        64'(mon.state), 64'd1);
      ticks(34);
      check("a_t40",        mon.sim_time, 64'd40);
      check("a_noerr",      64'(mon.err_valid), 64'd0);
      mon.chan_error = 4'b0100;
      tick();
      mon.chan_error = 4'b0000;
      check("a_valid",      64'(mon.err_valid), 64'd1);
      check("a_chan",       64'(mon.err_chan), 64'd2);
      check("a_code",       64'(mon.err_code), 64'd1);
      check("a_etime",      mon.err_time, 64'd40);
      check("a_drain",      64'(mon.state), 64'd2);
      check("a_sticky",     64'(mon.err_sticky), 64'h4);
      ticks(15);
      check("a_drain15",    64'(mon.state), 64'd2);
      check("a_nofin15",    64'(mon.finish_req), 64'd0);
      tick();
      check("a_done",       64'(mon.state), 64'd3);
      check("a_finish",     64'(mon.finish_req), 64'd1);
      mon.enable     = 1'b0;
      mon.chan_error = 4'b0001;
      tick();
      mon.chan_error = 4'b0000;
      check("a_done_hold",  64'(mon.state), 64'd3);
      check("a_sticky_acc", 64'(mon.err_sticky), 64'h5);
      check("a_chan_frz",   64'(mon.err_chan), 64'd2);
      check("a_etime_frz",  mon.err_time, 64'd40);
`ifdef TLX_SIM_MON_BREAKPOINT_EN
      check("a_bp_pulses",  64'(bpCount - bpStart), 64'd2);
`endif

      // Simultaneous errors on ch3 and ch1: lowest index wins.
      doReset();
      mon.chan_heartbeat = 4'b1111;
      mon.enable = 1'b1;
      tick();
      mon.chan_error = 4'b1010;
      tick();
      mon.chan_error = 4'b0000;
      check("b_chan",       64'(mon.err_chan), 64'd1);
      check("b_code",       64'(mon.err_code), 64'd1);
      check("b_sticky",     64'(mon.err_sticky), 64'hA);
      check("b_drain",      64'(mon.state), 64'd2);

      // Watchdog timeout on ch0 after 8 heartbeat-free RUN cycles.
      doReset();
      mon.chan_mask = 4'b1110;
      mon.enable = 1'b1;
      ticks(8);
      check("c_pre_valid",  64'(mon.err_valid), 64'd0);
      check("c_pre_state",  64'(mon.state), 64'd1);
      tick();
      check("c_valid",      64'(mon.err_valid), 64'd1);
      check("c_code",       64'(mon.err_code), 64'd2);
      check("c_chan",       64'(mon.err_chan), 64'd0);
      check("c_etime",      mon.err_time, 64'd8);
      check("c_sticky",     64'(mon.err_sticky), 64'h1);
      check("c_drain",      64'(mon.state), 64'd2);

      // Error flag and timeout on the same channel, same cycle: flag code.
      doReset();
      mon.chan_mask = 4'b1110;
      mon.enable = 1'b1;
      ticks(8);
      mon.chan_error = 4'b0001;
      tick();
      mon.chan_error = 4'b0000;
      check("c2_code",      64'(mon.err_code), 64'd1);
      check("c2_sticky",    64'(mon.err_sticky), 64'h1);

      // Heartbeat every 5 cycles keeps ch0 alive; enable=0 returns to IDLE.
      doReset();
      mon.chan_mask = 4'b1110;
      mon.enable = 1'b1;
      tick();
      for (int i = 0; i < 60; i++) begin
         mon.chan_heartbeat = (i % 5 == 0) ? 4'b0001 : 4'b0000;
         tick();
      end
      check("d_noerr",      64'(mon.err_valid), 64'd0);
      check("d_run",        64'(mon.state), 64'd1);
      check("d_sticky",     64'(mon.err_sticky), 64'd0);
      mon.enable = 1'b0;
      tick();
      check("d_idle",       64'(mon.state), 64'd0);

      // Masked ch1 error ignored, then captured the cycle after unmasking.
      doReset();
      mon.chan_heartbeat = 4'b1111;
      mon.chan_mask  = 4'b0010;
      mon.chan_error = 4'b0010;
      mon.enable = 1'b1;
      ticks(4);
      check("e_run",        64'(mon.state), 64'd1);
      check("e_noerr",      64'(mon.err_valid), 64'd0);
      check("e_nosticky",   64'(mon.err_sticky), 64'd0);
      mon.chan_mask = 4'b0000;
      tick();
      check("e_valid",      64'(mon.err_valid), 64'd1);
      check("e_chan",       64'(mon.err_chan), 64'd1);
      check("e_drain",      64'(mon.state), 64'd2);

      // Reset asserted mid-DRAIN clears everything at once.
      doReset();
      mon.chan_heartbeat = 4'b1111;
      mon.enable = 1'b1;
      tick();
      mon.chan_error = 4'b1000;
      tick();
      mon.chan_error = 4'b0000;
      ticks(3);
      check("f_in_drain",   64'(mon.state), 64'd2);
      ha_reset = 1'b1;
      #1;
      check("f_state",      64'(mon.state), 64'd0);
      check("f_valid",      64'(mon.err_valid), 64'd0);
      check("f_time",       mon.sim_time, 64'd0);
      check("f_sticky",     64'(mon.err_sticky), 64'd0);
      ticks(20);
      check("f_nofinish",   64'(mon.finish_req), 64'd0);
      check("f_state_hold", 64'(mon.state), 64'd0);
      ha_reset = 1'b0;

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/tlx_sim_monitor.md
Name: tlx_sim_monitor

Overview:
- Parametrised simulation supervisor for the TLX/AFU bench top.
- Keeps a cycle-accurate simulation time, aggregates per-channel error flags, and runs per-channel heartbeat watchdogs.
- Sequences an orderly end of test (RUN -> DRAIN -> DONE) and raises finish_req; the bench top calls $finish on it.
- Replaces single-flag error/finish handling with an N-channel version that records the first error.

Parameters:
- NUM_CHAN, 4, number of monitored channels (1..32).
- CHAN_W, 5, width of err_chan; must satisfy 2**CHAN_W >= NUM_CHAN.
- TIME_W, 64, width of sim_time and err_time.
- WDOG_W, 16, width of each watchdog counter.
- TIMEOUT, 1000, heartbeat-free cycles before a timeout error; 0 disables all watchdogs.
- DRAIN_CYCLES, 16, cycles spent in DRAIN before DONE.

Ports:
- ha_pclock  in  1  bench clock; all logic on posedge.
- ha_reset  in  1  asynchronous, active-high reset.
- enable  in  1  start/continue monitoring.
- chan_mask  in  NUM_CHAN  1 = channel ignored (no error, no watchdog).
- chan_error  in  NUM_CHAN  per-channel error level, sampled each cycle.
- chan_heartbeat  in  NUM_CHAN  per-channel activity pulse.
- sim_time  out  TIME_W  cycle count since reset.
- state  out  2  00 IDLE, 01 RUN, 10 DRAIN, 11 DONE.
- err_valid  out  1  first error captured (sticky).
- err_chan  out  CHAN_W  channel of the first error.
- err_code  out  2  01 error flag, 10 watchdog timeout.
- err_time  out  TIME_W  sim_time value on the cycle the first error was sampled.
- err_sticky  out  NUM_CHAN  per-channel OR of all errors and timeouts seen.
- finish_req  out  1  level; high in DONE.

Behaviour:
- Reset (async, ha_reset=1): all outputs 0, state IDLE, watchdogs 0, drain counter 0.
- sim_time: +1 every cycle after reset, any state; wraps modulo 2**TIME_W.
- IDLE: errors and watchdogs ignored; enable=1 -> RUN on the next edge.
- RUN:
  - Channel i is active when chan_mask[i]=0.
  - Each active watchdog clears on chan_heartbeat[i], otherwise increments.
  - Timeout fires when the count reaches TIMEOUT-1 with no heartbeat; the counter then saturates (no refire).
  - Any active error or timeout -> DRAIN on the next edge.
  - enable=0 with no error -> IDLE; watchdogs cleared, err_sticky retained.
- Error vs heartbeat on the same channel, same cycle: the error wins.
- Error flag and timeout on the same channel, same cycle: err_code=01; err_sticky set once.
- First-error capture (err_valid=0 only):
  - Lowest-index active channel wins.
  - err_valid, err_chan, err_code and err_time are registered one cycle after sampling.
  - The fields then hold until reset.
- DRAIN:
  - The drain counter counts 0..DRAIN_CYCLES-1, then state goes to DONE.
  - DRAIN_CYCLES=0 -> DONE on the first cycle after entry.
  - err_sticky keeps accumulating; first-error fields are frozen; enable is ignored.
- DONE: finish_req=1; terminal until ha_reset; err_sticky still accumulates.
- Reset mid-DRAIN/DONE: everything cleared immediately; no finish_req glitch.
- Masking a channel mid-RUN clears its watchdog that cycle.

Optional Feature:
- Macro: TLX_SIM_MON_BREAKPOINT_EN.
- Defined:
  - Adds output breakpoint (1 bit).
  - One-cycle pulse, coincident with the cycle err_valid first rises.
  - Also pulses once on entry to DONE.
  - Reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package tlx_sim_mon_pkg:
  - state encoding enum: IDLE, RUN, DRAIN, DONE.
  - err_code constants: ERR_FLAG=2'b01, ERR_TIMEOUT=2'b10.
  - a priority-encoder function (lowest set bit -> index).
- Sub-module tlx_sim_wdog: one saturating watchdog counter with clear, enable and timeout pulse; instantiated NUM_CHAN times in a generate loop.

Test Plan:
- Reset then idle 10 cycles -> sim_time=10, state=00, all error outputs 0, finish_req=0.
- Stimulus: enable at cycle 5; chan_error[2]=1 at sim_time 40; DRAIN_CYCLES=16.
  - Response: err_valid=1, err_chan=2, err_code=01, err_time=40, state=10.
  - Then finish_req=1 exactly 16 cycles after DRAIN entry.
- Simultaneous errors on channels 3 and 1 -> err_chan=1; err_sticky=4'b1010.
- TIMEOUT=8 and no heartbeat on channel 0 -> err_code=10, err_chan=0 after 8 RUN cycles.
  - With a heartbeat every 5 cycles, no error ever occurs.
- chan_mask[1]=1 with chan_error[1]=1 -> no error, state stays RUN.
  - Unmasking -> error captured on the next cycle.
- ha_reset asserted during DRAIN -> state=00 and err_valid=0 immediately, no finish_req.
  - With TLX_SIM_MON_BREAKPOINT_EN, breakpoint pulses exactly twice in a full error run.
